// File: rtl/mcash_pkg.sv
// Shared types and constants for the mcash request path.
package mcash_pkg;

    localparam int unsigned MCASH_CH_NUM   = 3;
    localparam int unsigned MCASH_BANK_NUM = 4;
    localparam int unsigned MCASH_ADDR_W   = 28;
    localparam int unsigned MCASH_DATA_W   = 128;

    typedef logic [1:0] mcash_ch_id_t;

    typedef struct packed {
        logic [2:0]   op;
        logic [31:4]  addr;
        logic [127:0] data;
    } mcash_req_t;

    // Reduce a value in 0..5 modulo 3.
    function automatic logic [1:0] mcash_wrap3(input logic [2:0] v);
        logic [2:0] r;
        r = (v >= 3'd3) ? v - 3'd3 : v;
        return r[1:0];
    endfunction

endpackage

// File: rtl/mcash_rr_arb3.sv
// Combinational 3-way round-robin arbiter; search starts at ptr_i.
module mcash_rr_arb3
    import mcash_pkg::*;
(
    input  logic [2:0] req_i,
    input  logic [1:0] ptr_i,
    output logic [2:0] gnt_o,
    output logic [1:0] idx_o,
    output logic       valid_o
);

    logic [1:0] start;
    logic [1:0] pos;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        pos     = '0;
        // An out-of-range pointer behaves like 0.
        start   = (ptr_i == 2'd3) ? 2'd0 : ptr_i;
        for (int k = 0; k < 3; k++) begin
            pos = mcash_wrap3({1'b0, start} + 3'(k));
            if (!valid_o && req_i[pos]) begin
                valid_o    = 1'b1;
                gnt_o[pos] = 1'b1;
                idx_o      = pos;
            end
        end
    end

endmodule

// File: rtl/mcash_bank_arb.sv
// Steers channel requests to cache banks with per-bank round-robin and a
// one-entry registered slot per bank tagged with the source channel.
module mcash_bank_arb
    import mcash_pkg::*;
#(
    parameter int unsigned CH_NUM   = MCASH_CH_NUM,
    parameter int unsigned BANK_NUM = MCASH_BANK_NUM,
    parameter int unsigned ADDR_W   = MCASH_ADDR_W,
    parameter int unsigned DATA_W   = MCASH_DATA_W
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [CH_NUM-1:0]          ch_req_valid_i,
    output logic [CH_NUM-1:0]          ch_req_allowIn_o,
    input  logic [CH_NUM*3-1:0]        ch_req_op_i,
    input  logic [CH_NUM*ADDR_W-1:0]   ch_req_addr_i,
    input  logic [CH_NUM*DATA_W-1:0]   ch_req_data_i,
    output logic [BANK_NUM-1:0]        bank_req_valid_o,
    input  logic [BANK_NUM-1:0]        bank_req_ready_i,
    output logic [BANK_NUM*3-1:0]      bank_req_op_o,
    output logic [BANK_NUM*ADDR_W-1:0] bank_req_addr_o,
    output logic [BANK_NUM*DATA_W-1:0] bank_req_data_o,
    output logic [BANK_NUM*2-1:0]      bank_req_src_o
);

    mcash_req_t   [CH_NUM-1:0]              ch_req;
    logic         [BANK_NUM-1:0]            slot_free;
    logic         [BANK_NUM-1:0][CH_NUM-1:0] arb_req;
    logic         [BANK_NUM-1:0][CH_NUM-1:0] arb_gnt;
    logic         [BANK_NUM-1:0][1:0]       arb_idx;
    logic         [BANK_NUM-1:0]            arb_valid;
    logic         [CH_NUM-1:0]              allow;

    logic         [BANK_NUM-1:0]            valid_q;
    logic         [BANK_NUM-1:0][1:0]       ptr_q;
    mcash_req_t   [BANK_NUM-1:0]            slot_q;
    mcash_ch_id_t [BANK_NUM-1:0]            src_q;

    always_comb begin
        for (int c = 0; c < CH_NUM; c++) begin
            ch_req[c].op   = ch_req_op_i[c*3 +: 3];
            ch_req[c].addr = ch_req_addr_i[c*ADDR_W +: ADDR_W];
            ch_req[c].data = ch_req_data_i[c*DATA_W +: DATA_W];
        end
    end

    // A slot can take a new request when empty or draining this cycle.
    always_comb begin
        for (int b = 0; b < BANK_NUM; b++) begin
            slot_free[b] = !valid_q[b] || bank_req_ready_i[b];
            for (int c = 0; c < CH_NUM; c++) begin
                arb_req[b][c] = slot_free[b] && ch_req_valid_i[c] &&
                                (ch_req[c].addr[5:4] == b[1:0]);
            end
        end
    end

    for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank
        mcash_rr_arb3 u_arb (
            .req_i   (arb_req[b]),
            .ptr_i   (ptr_q[b]),
            .gnt_o   (arb_gnt[b]),
            .idx_o   (arb_idx[b]),
            .valid_o (arb_valid[b])
        );
    end

    // Each channel targets exactly one bank, so at most one grant lands here.
    always_comb begin
        allow = '0;
        for (int b = 0; b < BANK_NUM; b++) begin
            allow = allow | arb_gnt[b];
        end
        ch_req_allowIn_o = rst_i ? '0 : allow;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            ptr_q   <= '0;
            slot_q  <= '0;
            src_q   <= '0;
        end else begin
            for (int b = 0; b < BANK_NUM; b++) begin
                if (arb_valid[b]) begin
                    valid_q[b] <= 1'b1;
                    slot_q[b]  <= ch_req[arb_idx[b]];
                    src_q[b]   <= arb_idx[b];
                    ptr_q[b]   <= mcash_wrap3({1'b0, arb_idx[b]} + 3'd1);
                end else if (bank_req_ready_i[b]) begin
                    valid_q[b] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        bank_req_valid_o = valid_q;
        bank_req_op_o    = '0;
        bank_req_addr_o  = '0;
        bank_req_data_o  = '0;
        bank_req_src_o   = '0;
        for (int b = 0; b < BANK_NUM; b++) begin
            bank_req_op_o[b*3 +: 3]           = slot_q[b].op;
            bank_req_addr_o[b*ADDR_W +: ADDR_W] = slot_q[b].addr;
            bank_req_data_o[b*DATA_W +: DATA_W] = slot_q[b].data;
            bank_req_src_o[b*2 +: 2]          = src_q[b];
        end
    end

endmodule

// File: tb/tb_mcash_bank_arb.sv
// Scoreboard bench for mcash_bank_arb: directed grants push expected bank
// transfers; a monitor pops and compares on every bank valid & ready.
module tb_mcash_bank_arb;

    typedef struct packed {
        logic [2:0]   op;
        logic [27:0]  addr;
        logic [127:0] data;
        logic [1:0]   src;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [2:0]    ch_req_valid_i;
    logic [2:0]    ch_req_allowIn_o;
    logic [8:0]    ch_req_op_i;
    logic [83:0]   ch_req_addr_i;
    logic [383:0]  ch_req_data_i;
    logic [3:0]    bank_req_valid_o;
    logic [3:0]    bank_req_ready_i;
    logic [11:0]   bank_req_op_o;
    logic [111:0]  bank_req_addr_o;
    logic [511:0]  bank_req_data_o;
    logic [7:0]    bank_req_src_o;

    int   n_cmp = 0;
    int   n_err = 0;
    logic [23:0] tag = 24'h000100;
    exp_t exp_q[4][$];
    exp_t held;

    always #5 clk = ~clk;

    mcash_bank_arb dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .ch_req_valid_i   (ch_req_valid_i),
        .ch_req_allowIn_o (ch_req_allowIn_o),
        .ch_req_op_i      (ch_req_op_i),
        .ch_req_addr_i    (ch_req_addr_i),
        .ch_req_data_i    (ch_req_data_i),
        .bank_req_valid_o (bank_req_valid_o),
        .bank_req_ready_i (bank_req_ready_i),
        .bank_req_op_o    (bank_req_op_o),
        .bank_req_addr_o  (bank_req_addr_o),
        .bank_req_data_o  (bank_req_data_o),
        .bank_req_src_o   (bank_req_src_o)
    );

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t bank_out(input int b);
        exp_t a;
        a.op   = bank_req_op_o[b*3 +: 3];
        a.addr = bank_req_addr_o[b*28 +: 28];
        a.data = bank_req_data_o[b*128 +: 128];
        a.src  = bank_req_src_o[b*2 +: 2];
        return a;
    endfunction

    // Drive one cycle of stimulus, check allowIn mid-cycle, and queue the
    // bank transfers that the hand-computed grant vector implies.
    task automatic step(input string name, input logic [2:0] v, input logic [1:0] b0,
                        input logic [1:0] b1, input logic [1:0] b2, input logic [3:0] rdy,
                        input logic [2:0] exp_allow);
        logic [1:0] bk[3];
        exp_t e;
        bk[0] = b0;
        bk[1] = b1;
        bk[2] = b2;
        tag   = tag + 24'd1;
        for (int c = 0; c < 3; c++) begin
            ch_req_valid_i[c]             = v[c];
            ch_req_addr_i[c*28 +: 28]     = {tag, 2'(c), bk[c]};
            ch_req_op_i[c*3 +: 3]         = tag[2:0] ^ 3'(c);
            ch_req_data_i[c*128 +: 128]   = {tag, 8'(c), 96'hA5A5_0000_5A5A_1111_C3C3_2222};
        end
        bank_req_ready_i = rdy;
        @(negedge clk);
        check({name, "_allow"}, 192'(ch_req_allowIn_o), 192'(exp_allow));
        for (int c = 0; c < 3; c++) begin
            if (exp_allow[c]) begin
                e.op   = ch_req_op_i[c*3 +: 3];
                e.addr = ch_req_addr_i[c*28 +: 28];
                e.data = ch_req_data_i[c*128 +: 128];
                e.src  = 2'(c);
                exp_q[bk[c]].push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t a;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_i) begin
                for (int b = 0; b < 4; b++) begin
                    if (bank_req_valid_o[b] && bank_req_ready_i[b]) begin
                        a = bank_out(b);
                        if (exp_q[b].size() == 0) begin
                            n_cmp++;
                            n_err++;
                            $display("FAIL bank%0d_unexpected: got %0h expected none", b, a);
                        end else begin
                            e = exp_q[b].pop_front();
                            check($sformatf("bank%0d_out", b), 192'(a), 192'(e));
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : driver
        rst_i            = 1'b1;
        ch_req_valid_i   = '0;
        ch_req_op_i      = '0;
        ch_req_addr_i    = '0;
        ch_req_data_i    = '0;
        bank_req_ready_i = '0;

        // allowIn forced low under reset even with valid requests.
        step("rst", 3'b111, 2'd0, 2'd0, 2'd0, 4'hF, 3'b000);
        step("rst2", 3'b111, 2'd1, 2'd2, 2'd3, 4'hF, 3'b000);
        rst_i = 1'b0;
        check("rst_valid", 192'(bank_req_valid_o), 192'(0));
        check("rst_src", 192'(bank_req_src_o), 192'(0));
        check("rst_addr", 192'(bank_req_addr_o), 192'(0));

        // Single request to bank 1.
        step("single", 3'b001, 2'd1, 2'd0, 2'd0, 4'hF, 3'b001);
        check("single_valid", 192'(bank_req_valid_o), 192'(4'b0010));

        // Three channels to three banks at once.
        step("parallel", 3'b111, 2'd0, 2'd1, 2'd2, 4'hF, 3'b111);
        check("parallel_valid", 192'(bank_req_valid_o), 192'(4'b0111));
        check("parallel_src", 192'(bank_req_src_o[5:0]), 192'(6'b10_01_00));

        // All three contend for bank 3: 0,1,2,0,1,2.
        for (int i = 0; i < 6; i++) begin
            step($sformatf("rr%0d", i), 3'b111, 2'd3, 2'd3, 2'd3, 4'hF, 3'(1 << (i % 3)));
            check($sformatf("rr%0d_valid", i), 192'(bank_req_valid_o[3]), 192'(1));
        end
        step("drain1", 3'b000, 2'd0, 2'd0, 2'd0, 4'hF, 3'b000);
        check("drain1_valid", 192'(bank_req_valid_o), 192'(0));

        // Backpressure on bank 2.
        step("bp_fill", 3'b010, 2'd0, 2'd2, 2'd0, 4'b1011, 3'b010);
        held = exp_q[2][0];
        for (int i = 0; i < 5; i++) begin
            step($sformatf("bp_hold%0d", i), 3'b010, 2'd0, 2'd2, 2'd0, 4'b1011, 3'b000);
            check($sformatf("bp_hold%0d_slot", i), 192'(bank_out(2)), 192'(held));
            check($sformatf("bp_hold%0d_valid", i), 192'(bank_req_valid_o), 192'(4'b0100));
        end
        step("bp_release", 3'b010, 2'd0, 2'd2, 2'd0, 4'hF, 3'b010);
        check("bp_release_valid", 192'(bank_req_valid_o), 192'(4'b0100));
        check("bp_release_src", 192'(bank_req_src_o[5:4]), 192'(1));
        step("drain2", 3'b000, 2'd0, 2'd0, 2'd0, 4'hF, 3'b000);

        // Reset while bank 0 holds a request; ptr[0] is 1 beforehand.
        step("pre_rst", 3'b001, 2'd0, 2'd0, 2'd0, 4'b1110, 3'b001);
        rst_i = 1'b1;
        step("mid_rst", 3'b101, 2'd0, 2'd0, 2'd0, 4'b1110, 3'b000);
        rst_i = 1'b0;
        exp_q[0].delete();
        check("mid_rst_valid", 192'(bank_req_valid_o), 192'(0));
        step("post_rst0", 3'b101, 2'd0, 2'd0, 2'd0, 4'hF, 3'b001);
        step("post_rst1", 3'b101, 2'd0, 2'd0, 2'd0, 4'hF, 3'b100);
        step("drain3", 3'b000, 2'd0, 2'd0, 2'd0, 4'hF, 3'b000);
        step("drain4", 3'b000, 2'd0, 2'd0, 2'd0, 4'hF, 3'b000);

        for (int b = 0; b < 4; b++) begin
            check($sformatf("q%0d_left", b), 192'(exp_q[b].size()), 192'(0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
